// File: rtl/pgm_ddram_arbiter.sv
// rtl/pgm_ddram_arbiter.sv - shares the DDRAM read port among pgm_video fetch requesters
//
// Fixed index priority (0 highest) with an age override; one read in flight at a time.
// Ports:
//   clk, reset_n          core clock, synchronous active-low reset
//   req, req_addr         per-requester request level and address slice [i*ADDR_W +: ADDR_W]
//   grant, rvalid, rerr   one-hot 1-cycle pulses: accepted / data returned / timed out
//   rdata                 last returned beat, held until the next return
//   ddram_rd, ddram_addr  read strobe and address toward DDRAM
//   ddram_dout, ddram_busy, ddram_dout_ready   DDRAM read data and handshake
//   arb_busy              state is not IDLE
//   timeout_err, err_clr  sticky timeout flag and its clear
module pgm_ddram_arbiter #(
   parameter int NUM_REQ   = 3,
   parameter int ADDR_W    = 29,
   parameter int DATA_W    = 64,
   parameter int AGE_LIMIT = 8,
   parameter int TIMEOUT   = 255
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        grant,
   output logic [NUM_REQ-1:0]        rvalid,
   output logic [NUM_REQ-1:0]        rerr,
   output logic [DATA_W-1:0]         rdata,
   output logic                      ddram_rd,
   output logic [ADDR_W-1:0]         ddram_addr,
   input  logic [DATA_W-1:0]         ddram_dout,
   input  logic                      ddram_busy,
   input  logic                      ddram_dout_ready,
   output logic                      arb_busy,
   output logic                      timeout_err,
   input  logic                      err_clr
);

   localparam int AGE_W = $clog2(AGE_LIMIT + 1);
   localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t             state, state_nxt;
   logic [AGE_W-1:0]   age [NUM_REQ];
   logic [OWN_W-1:0]   owner;
   logic [TMO_W-1:0]   tmo_cnt;

   logic               base_any, aged_any, win_any;
   logic [OWN_W-1:0]   base_idx, aged_idx, win_idx;
   logic [NUM_REQ-1:0] holder;
   logic               do_grant, do_issue, do_return, do_timeout;

   // Descending scans so the last hit, i.e. the lowest index, is kept.
   // An aged requester must still be requesting to be picked.
   always_comb begin
      base_any = 1'b0;
      base_idx = '0;
      aged_any = 1'b0;
      aged_idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            base_any = 1'b1;
            base_idx = OWN_W'(i);
         end
         if (req[i] && age[i] == AGE_W'(AGE_LIMIT)) begin
            aged_any = 1'b1;
            aged_idx = OWN_W'(i);
         end
      end
      win_any = base_any;
      win_idx = aged_any ? aged_idx : base_idx;
   end

   // The requester that is not ageing this cycle: the winner while arbitrating,
   // the owner while its read is in flight.
   always_comb begin
      holder = '0;
      if (state == S_IDLE) begin
         if (win_any) holder[win_idx] = 1'b1;
      end else begin
         holder[owner] = 1'b1;
      end
   end

   always_comb begin
      state_nxt  = state;
      do_grant   = 1'b0;
      do_issue   = 1'b0;
      do_return  = 1'b0;
      do_timeout = 1'b0;
      case (state)
         S_IDLE: begin
            if (win_any) begin
               do_grant  = 1'b1;
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!ddram_busy) begin
               do_issue  = 1'b1;
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (ddram_dout_ready) begin
               do_return = 1'b1;
               state_nxt = S_IDLE;
            end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
               do_timeout = 1'b1;
               state_nxt  = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         owner       <= '0;
         ddram_addr  <= '0;
         ddram_rd    <= 1'b0;
         grant       <= '0;
         rvalid      <= '0;
         rerr        <= '0;
         rdata       <= '0;
         tmo_cnt     <= '0;
         timeout_err <= 1'b0;
      end else begin
         state    <= state_nxt;
         grant    <= '0;
         rvalid   <= '0;
         rerr     <= '0;
         ddram_rd <= do_issue;
         if (do_grant) begin
            owner      <= win_idx;
            ddram_addr <= req_addr[win_idx*ADDR_W +: ADDR_W];
            grant      <= NUM_REQ'(1) << win_idx;
         end
         if (do_issue) begin
            tmo_cnt <= '0;
         end else if (state == S_WAIT) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
         if (do_return) begin
            rdata  <= ddram_dout;
            rvalid <= NUM_REQ'(1) << owner;
         end
         if (do_timeout) begin
            rerr <= NUM_REQ'(1) << owner;
         end
         // A timeout in the same cycle as err_clr keeps the flag set.
         if (do_timeout) begin
            timeout_err <= 1'b1;
         end else if (err_clr) begin
            timeout_err <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!reset_n || !req[i] || holder[i]) begin
            age[i] <= '0;
         end else if (age[i] != AGE_W'(AGE_LIMIT)) begin
            age[i] <= age[i] + 1'b1;
         end
      end
   end

   assign arb_busy = (state != S_IDLE);

endmodule

// File: tb/tb_pgm_ddram_arbiter.sv
// tb/tb_pgm_ddram_arbiter.sv - scoreboard bench for pgm_ddram_arbiter
module tb_pgm_ddram_arbiter;

   localparam int NR = 3;
   localparam int AW = 29;
   localparam int DW = 64;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [NR-1:0]    req;
   logic [NR*AW-1:0] req_addr;
   logic [NR-1:0]    grant, rvalid, rerr;
   logic [DW-1:0]    rdata;
   logic             ddram_rd;
   logic [AW-1:0]    ddram_addr;
   logic [DW-1:0]    ddram_dout;
   logic             ddram_busy, ddram_dout_ready;
   logic             arb_busy, timeout_err, err_clr;

   always #5 clk = ~clk;

   pgm_ddram_arbiter #(
      .NUM_REQ(3), .ADDR_W(29), .DATA_W(64), .AGE_LIMIT(8), .TIMEOUT(16)
   ) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .req_addr(req_addr),
      .grant(grant), .rvalid(rvalid), .rerr(rerr), .rdata(rdata),
      .ddram_rd(ddram_rd), .ddram_addr(ddram_addr), .ddram_dout(ddram_dout),
      .ddram_busy(ddram_busy), .ddram_dout_ready(ddram_dout_ready),
      .arb_busy(arb_busy), .timeout_err(timeout_err), .err_clr(err_clr)
   );

   typedef enum logic [1:0] {EV_GRANT, EV_RD, EV_RVALID, EV_RERR} ev_kind_t;
   typedef struct packed {
      ev_kind_t    kind;
      logic [1:0]  idx;
      logic [63:0] val;
   } ev_t;

   ev_t exp_q[$];
   int  n_cmp  = 0;
   int  n_fail = 0;

   int          lat       = 1;
   bit          ddr_en    = 1'b1;
   bit          use_fixed = 1'b0;
   bit          stray_req = 1'b0;
   logic [63:0] fixed_data;
   int          pending   = 0;
   logic [28:0] lat_addr;

   logic [28:0] t2_addr [3] = '{29'h0000100, 29'h0000200, 29'h0000300};
   int          t2_order[7] = '{0, 0, 1, 2, 0, 1, 2};

   function automatic logic [63:0] beat_of(input logic [28:0] a);
      return {a, 35'h5_1234_5678};
   endfunction

   function automatic logic [1:0] idx_of(input logic [2:0] v);
      logic [1:0] r = 2'd0;
      for (int i = 2; i >= 0; i--) if (v[i]) r = 2'(i);
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_addr(input int i, input logic [28:0] a);
      req_addr[i*AW +: AW] = a;
   endtask

   task automatic push(input ev_kind_t k, input int i, input logic [63:0] v);
      ev_t e;
      e.kind = k;
      e.idx  = 2'(i);
      e.val  = v;
      exp_q.push_back(e);
   endtask

   task automatic push_read(input int i, input logic [28:0] a, input logic [63:0] d);
      push(EV_GRANT, i, 64'(a));
      push(EV_RD, 0, 64'(a));
      push(EV_RVALID, i, d);
   endtask

   task automatic wait_grant(input string name, input int max);
      int n = 0;
      while (grant == '0 && n < max) begin
         tick(1);
         n++;
      end
      if (grant == '0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: no grant within %0d cycles", name, max);
      end
   endtask

   task automatic wait_drain(input string name, input int max);
      int n = 0;
      while ((exp_q.size() != 0 || arb_busy) && n < max) begin
         tick(1);
         n++;
      end
      n_cmp++;
      if (exp_q.size() != 0 || arb_busy) begin
         n_fail++;
         $display("FAIL %s: %0d events outstanding, arb_busy %0b after %0d cycles",
                  name, exp_q.size(), arb_busy, max);
         exp_q.delete();
      end
      tick(1);
   endtask

   // DDRAM read model: answers a strobe after lat cycles, or a stray beat on demand.
   initial begin
      ddram_dout_ready = 1'b0;
      ddram_dout       = '0;
      forever begin
         @(negedge clk);
         ddram_dout_ready = 1'b0;
         if (pending > 0) begin
            pending--;
            if (pending == 0) begin
               ddram_dout_ready = 1'b1;
               ddram_dout       = use_fixed ? fixed_data : beat_of(lat_addr);
            end
         end else if (stray_req) begin
            stray_req        = 1'b0;
            ddram_dout_ready = 1'b1;
            ddram_dout       = 64'h1111_2222_3333_4444;
         end
         if (ddram_rd && ddr_en) begin
            pending  = lat;
            lat_addr = ddram_addr;
         end
      end
   end

   // Monitor: every grant / strobe / return / error is matched against the queue.
   initial begin
      forever begin : mon
         ev_t obs;
         ev_t e;
         @(negedge clk);
         if ((grant | rvalid | rerr) != '0 || ddram_rd) begin
            chk("events_exclusive", 64'($countones({grant, rvalid, rerr, ddram_rd})), 64'd1);
            if (grant != '0) begin
               obs.kind = EV_GRANT;  obs.idx = idx_of(grant);  obs.val = 64'(ddram_addr);
            end else if (ddram_rd) begin
               obs.kind = EV_RD;     obs.idx = 2'd0;           obs.val = 64'(ddram_addr);
            end else if (rvalid != '0) begin
               obs.kind = EV_RVALID; obs.idx = idx_of(rvalid); obs.val = rdata;
            end else begin
               obs.kind = EV_RERR;   obs.idx = idx_of(rerr);   obs.val = rdata;
            end
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_event: got kind %0d idx %0d val %h expected none",
                        obs.kind, obs.idx, obs.val);
            end else begin
               e = exp_q.pop_front();
               chk("ev_kind", 64'(obs.kind), 64'(e.kind));
               chk("ev_idx", 64'(obs.idx), 64'(e.idx));
               chk("ev_val", obs.val, e.val);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int ng;
      reset_n    = 1'b0;
      req        = '0;
      req_addr   = '0;
      ddram_busy = 1'b0;
      err_clr    = 1'b0;
      fixed_data = '0;
      tick(3);
      reset_n = 1'b1;
      tick(1);

      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_rvalid", 64'(rvalid), 64'd0);
      chk("rst_rerr", 64'(rerr), 64'd0);
      chk("rst_rdata", rdata, 64'd0);
      chk("rst_ddram_rd", 64'(ddram_rd), 64'd0);
      chk("rst_ddram_addr", 64'(ddram_addr), 64'd0);
      chk("rst_arb_busy", 64'(arb_busy), 64'd0);
      chk("rst_timeout_err", 64'(timeout_err), 64'd0);

      // T1 single read from requester 1, data 5 cycles after the strobe
      lat        = 5;
      use_fixed  = 1'b1;
      fixed_data = 64'hDEADBEEF_CAFEF00D;
      set_addr(1, 29'h0123456);
      push_read(1, 29'h0123456, 64'hDEADBEEF_CAFEF00D);
      req = 3'b010;
      wait_grant("t1_grant", 10);
      req = '0;
      wait_drain("t1_done", 40);
      chk("t1_rdata", rdata, 64'hDEADBEEF_CAFEF00D);

      // T6 stray beat in IDLE
      stray_req = 1'b1;
      tick(4);
      chk("t6_rdata_held", rdata, 64'hDEADBEEF_CAFEF00D);
      chk("t6_arb_busy", 64'(arb_busy), 64'd0);

      // T3 busy stall for 20 cycles after grant
      lat        = 1;
      use_fixed  = 1'b0;
      ddram_busy = 1'b1;
      set_addr(0, 29'h1ABCDEF);
      push_read(0, 29'h1ABCDEF, beat_of(29'h1ABCDEF));
      req = 3'b001;
      wait_grant("t3_grant", 10);
      req = '0;
      for (int i = 0; i < 20; i++) begin
         chk("t3_rd_low", 64'(ddram_rd), 64'd0);
         chk("t3_addr_hold", 64'(ddram_addr), 64'h1ABCDEF);
         chk("t3_arb_busy", 64'(arb_busy), 64'd1);
         tick(1);
      end
      ddram_busy = 1'b0;
      chk("t3_rd_still_low", 64'(ddram_rd), 64'd0);
      tick(1);
      chk("t3_rd_pulse", 64'(ddram_rd), 64'd1);
      tick(1);
      chk("t3_rd_single", 64'(ddram_rd), 64'd0);
      wait_drain("t3_done", 20);

      // T2 all three held, 4-cycle latency: order 0,0,1,2,0,1,2
      lat = 4;
      for (int i = 0; i < 3; i++) set_addr(i, t2_addr[i]);
      for (int k = 0; k < 7; k++)
         push_read(t2_order[k], t2_addr[t2_order[k]], beat_of(t2_addr[t2_order[k]]));
      req = 3'b111;
      ng  = 0;
      n   = 0;
      while (ng < 7 && n < 200) begin
         tick(1);
         n++;
         if (grant != '0) ng++;
      end
      req = '0;
      chk("t2_grant_count", 64'(ng), 64'd7);
      wait_drain("t2_done", 40);

      // T4 timeout after 16 WAIT cycles, rdata untouched
      ddr_en = 1'b0;
      set_addr(2, 29'h0DEAD00);
      push(EV_GRANT, 2, 64'h0DEAD00);
      push(EV_RD, 0, 64'h0DEAD00);
      push(EV_RERR, 2, beat_of(29'h0000300));
      req = 3'b100;
      wait_grant("t4_grant", 10);
      req = '0;
      n = 0;
      while (!ddram_rd && n < 10) begin
         tick(1);
         n++;
      end
      n = 0;
      while (rerr == '0 && n < 40) begin
         tick(1);
         n++;
      end
      chk("t4_wait_cycles", 64'(n), 64'd16);
      chk("t4_timeout_err", 64'(timeout_err), 64'd1);
      chk("t4_arb_busy", 64'(arb_busy), 64'd0);
      tick(1);
      ddr_en = 1'b1;
      lat    = 2;
      set_addr(1, 29'h1555555);
      push_read(1, 29'h1555555, beat_of(29'h1555555));
      req = 3'b010;
      wait_grant("t4_next_grant", 10);
      req = '0;
      wait_drain("t4_next_done", 30);
      chk("t4_err_sticky", 64'(timeout_err), 64'd1);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      chk("t4_err_clr", 64'(timeout_err), 64'd0);

      // T5 reset in the middle of WAIT; the late beat must be ignored
      lat = 6;
      set_addr(0, 29'h0F0F0F0);
      push(EV_GRANT, 0, 64'h0F0F0F0);
      push(EV_RD, 0, 64'h0F0F0F0);
      req = 3'b001;
      wait_grant("t5_grant", 10);
      req = '0;
      n = 0;
      while (!ddram_rd && n < 10) begin
         tick(1);
         n++;
      end
      tick(1);
      reset_n = 1'b0;
      tick(1);
      reset_n = 1'b1;
      chk("t5_grant", 64'(grant), 64'd0);
      chk("t5_rvalid", 64'(rvalid), 64'd0);
      chk("t5_rdata", rdata, 64'd0);
      chk("t5_ddram_addr", 64'(ddram_addr), 64'd0);
      chk("t5_arb_busy", 64'(arb_busy), 64'd0);
      tick(8);
      chk("t5_late_rdata", rdata, 64'd0);
      chk("t5_late_arb_busy", 64'(arb_busy), 64'd0);

      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
